// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU and DMA requester ports plus the shared single-port memory bus.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface mem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_done;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU and a DMA requester.
// Each transfer takes WAIT access cycles followed by a one-cycle done pulse to its owner.
module mem_port_arbiter #(
    parameter int unsigned WAIT = 2
) (
    input  logic              CLK,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT - 1);

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic        last_owner_r;
    logic        owner_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] cpu_rdata_r;
    logic [31:0] dma_rdata_r;
    logic        cpu_done_r;
    logic        dma_done_r;
    logic        mem_en_r;
    logic        mem_we_r;
    logic        busy_r;

    logic        grant_s;
    logic        sel_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    // Grant decision: a lone request wins outright, a tie goes to whoever was not served last.
    always_comb begin
        grant_s = 1'b0;
        sel_s   = last_owner_r;
        if (bus.cpu_req && bus.dma_req) begin
            grant_s = 1'b1;
            sel_s   = ~last_owner_r;
        end else if (bus.cpu_req) begin
            grant_s = 1'b1;
            sel_s   = 1'b0;
        end else if (bus.dma_req) begin
            grant_s = 1'b1;
            sel_s   = 1'b1;
        end else begin
            grant_s = 1'b0;
            sel_s   = last_owner_r;
        end
    end

    // Request field mux for the requester about to be granted.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        if (sel_s) begin
            sel_we_s    = bus.dma_we;
            sel_addr_s  = bus.dma_addr;
            sel_wdata_s = bus.dma_wdata;
        end else begin
            sel_we_s    = bus.cpu_we;
            sel_addr_s  = bus.cpu_addr;
            sel_wdata_s = bus.cpu_wdata;
        end
    end

    // Arbitration FSM; every output is a register so the memory bus only ever sees latched values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            last_owner_r <= 1'b1;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            cpu_rdata_r  <= 32'h0000_0000;
            dma_rdata_r  <= 32'h0000_0000;
            cpu_done_r   <= 1'b0;
            dma_done_r   <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_done_r <= 1'b0;
                    dma_done_r <= 1'b0;
                    if (grant_s) begin
                        state_r      <= ACCESS;
                        cnt_r        <= CNT_LOAD;
                        owner_r      <= sel_s;
                        last_owner_r <= sel_s;
                        we_r         <= sel_we_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        mem_en_r     <= 1'b1;
                        mem_we_r     <= sel_we_s;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 3'd0) begin
                        state_r    <= DONE;
                        mem_en_r   <= 1'b0;
                        mem_we_r   <= 1'b0;
                        cpu_done_r <= ~owner_r;
                        dma_done_r <= owner_r;
                        // Read data is captured on the final access cycle, only into the owner's register.
                        if (!we_r) begin
                            if (owner_r) begin
                                dma_rdata_r <= bus.mem_rdata;
                            end else begin
                                cpu_rdata_r <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    cpu_done_r <= 1'b0;
                    dma_done_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 3'd0;
                    cpu_done_r <= 1'b0;
                    dma_done_r <= 1'b0;
                    mem_en_r   <= 1'b0;
                    mem_we_r   <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.dma_rdata = dma_rdata_r;
    assign bus.dma_done  = dma_done_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transfers push expected completions,
// a negedge monitor checks each done pulse, bus activity and read data against the queue.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    mem_port_arbiter_if b1();
    mem_port_arbiter_if b2();
    mem_port_arbiter_if b7();

    mem_port_arbiter #(.WAIT(1)) u_dut1 (.CLK(CLK), .rst(rst), .bus(b1));
    mem_port_arbiter #(.WAIT(2)) u_dut2 (.CLK(CLK), .rst(rst), .bus(b2));
    mem_port_arbiter #(.WAIT(7)) u_dut7 (.CLK(CLK), .rst(rst), .bus(b7));

    // Memory contents: fixed word at 0x40, address-derived pattern elsewhere.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C0A_0004;
        return {a[15:0], 16'hA5A5};
    endfunction

    assign b1.mem_rdata = mem_model(b1.mem_addr);
    assign b2.mem_rdata = mem_model(b2.mem_addr);
    assign b7.mem_rdata = mem_model(b7.mem_addr);

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cpu_rd;
        logic [31:0] dma_rd;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else pass_cnt++;
    endtask

    function automatic void push(input bit who, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] cpu_rd,
                                 input logic [31:0] dma_rd, input int due);
        exp_t e;
        e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
        e.cpu_rd = cpu_rd; e.dma_rd = dma_rd; e.due = due;
        exp_q.push_back(e);
    endfunction

    // Monitor: tallies the memory bus during each access and checks each done pulse.
    int en_cnt = 0;
    int we_cnt = 0;
    bit bus_ok = 1'b1;
    always @(negedge CLK) begin
        if (b2.cpu_done || b2.dma_done) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: got cpu_done=%0b dma_done=%0b expected none", b2.cpu_done, b2.dma_done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_pair", {30'd0, b2.cpu_done, b2.dma_done}, e.who ? 32'd1 : 32'd2);
                check("owner", {31'd0, b2.owner}, {31'd0, e.who});
                check("busy_in_done", {31'd0, b2.busy}, 32'd1);
                check("cpu_rdata", b2.cpu_rdata, e.cpu_rd);
                check("dma_rdata", b2.dma_rdata, e.dma_rd);
                check("done_cycle", cyc, e.due);
                check("mem_en_cycles", en_cnt, 32'd2);
                check("mem_we_cycles", we_cnt, e.we ? 32'd2 : 32'd0);
                check("bus_stable", {31'd0, bus_ok}, 32'd1);
            end
            en_cnt = 0; we_cnt = 0; bus_ok = 1'b1;
        end else if (b2.mem_en) begin
            en_cnt++;
            if (b2.mem_we) we_cnt++;
            if (exp_q.size() != 0) begin
                if (b2.mem_addr !== exp_q[0].addr || b2.mem_we !== exp_q[0].we) bus_ok = 1'b0;
                if (exp_q[0].we && b2.mem_wdata !== exp_q[0].wdata) bus_ok = 1'b0;
            end
        end else begin
            en_cnt = 0; we_cnt = 0; bus_ok = 1'b1;
        end
    end

    // Requester drivers: hold req until done is seen, then drop it before the edge ending DONE.
    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        b2.cpu_we = we; b2.cpu_addr = addr; b2.cpu_wdata = wdata; b2.cpu_req = 1'b1;
        do begin @(negedge CLK); n++; end while (!b2.cpu_done && n < 40);
        if (!b2.cpu_done) begin
            chk_cnt++;
            $display("FAIL cpu_timeout: got no cpu_done within %0d cycles, expected a done", n);
        end
        b2.cpu_req = 1'b0;
    endtask

    task automatic dma_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        b2.dma_we = we; b2.dma_addr = addr; b2.dma_wdata = wdata; b2.dma_req = 1'b1;
        do begin @(negedge CLK); n++; end while (!b2.dma_done && n < 40);
        if (!b2.dma_done) begin
            chk_cnt++;
            $display("FAIL dma_timeout: got no dma_done within %0d cycles, expected a done", n);
        end
        b2.dma_req = 1'b0;
    endtask

    initial begin
        int k;
        int n;
        b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0; b1.cpu_wdata = 32'h0;
        b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = 32'h0; b1.dma_wdata = 32'h0;
        b2.cpu_req = 1'b0; b2.cpu_we = 1'b0; b2.cpu_addr = 32'h0; b2.cpu_wdata = 32'h0;
        b2.dma_req = 1'b0; b2.dma_we = 1'b0; b2.dma_addr = 32'h0; b2.dma_wdata = 32'h0;
        b7.cpu_req = 1'b0; b7.cpu_we = 1'b0; b7.cpu_addr = 32'h0; b7.cpu_wdata = 32'h0;
        b7.dma_req = 1'b0; b7.dma_we = 1'b0; b7.dma_addr = 32'h0; b7.dma_wdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge CLK);

        check("rst_ctrl", {26'd0, b2.busy, b2.owner, b2.mem_en, b2.mem_we, b2.cpu_done, b2.dma_done}, 32'd0);
        check("rst_cpu_rdata", b2.cpu_rdata, 32'h0);
        check("rst_dma_rdata", b2.dma_rdata, 32'h0);
        check("rst_mem_addr", b2.mem_addr, 32'h0);
        check("rst_mem_wdata", b2.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge CLK);

        // Latency WAIT+1 on the WAIT=1 and WAIT=7 variants.
        b1.cpu_addr = 32'h40; b1.cpu_req = 1'b1; n = 0;
        do begin @(negedge CLK); n++; end while (!b1.cpu_done && n < 30);
        b1.cpu_req = 1'b0;
        check("w1_latency", n, 32'd2);
        check("w1_rdata", b1.cpu_rdata, 32'h8C0A_0004);
        b7.cpu_addr = 32'h40; b7.cpu_req = 1'b1; n = 0;
        do begin @(negedge CLK); n++; end while (!b7.cpu_done && n < 30);
        b7.cpu_req = 1'b0;
        check("w7_latency", n, 32'd8);
        check("w7_rdata", b7.cpu_rdata, 32'h8C0A_0004);
        @(negedge CLK);

        // Tie after reset: CPU first, then DMA.
        k = cyc;
        push(1'b0, 1'b0, 32'h40,  32'h0, 32'h8C0A_0004, 32'h0,         k + 3);
        push(1'b1, 1'b0, 32'h200, 32'h0, 32'h8C0A_0004, 32'h0200_A5A5, k + 7);
        fork
            cpu_access(1'b0, 32'h40, 32'h0);
            dma_access(1'b0, 32'h200, 32'h0);
        join
        @(negedge CLK);

        // Second tie: CPU again, DMA write leaves both rdata alone.
        k = cyc;
        push(1'b0, 1'b0, 32'h80,  32'h0,         32'h0080_A5A5, 32'h0200_A5A5, k + 3);
        push(1'b1, 1'b1, 32'h300, 32'h1111_2222, 32'h0080_A5A5, 32'h0200_A5A5, k + 7);
        fork
            cpu_access(1'b0, 32'h80, 32'h0);
            dma_access(1'b1, 32'h300, 32'h1111_2222);
        join
        @(negedge CLK);

        // Lone DMA write.
        k = cyc;
        push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0080_A5A5, 32'h0200_A5A5, k + 3);
        dma_access(1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge CLK);

        // CPU read with cpu_addr changed mid-access; bus must keep 0x40.
        k = cyc;
        push(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C0A_0004, 32'h0200_A5A5, k + 3);
        fork
            cpu_access(1'b0, 32'h40, 32'h0);
            begin @(negedge CLK); b2.cpu_addr = 32'h80; end
        join
        @(negedge CLK);

        // DMA held across CPU traffic: strict CPU/DMA alternation, nothing dropped.
        k = cyc;
        push(1'b0, 1'b0, 32'h44,  32'h0,         32'h0044_A5A5, 32'h0200_A5A5, k + 3);
        push(1'b1, 1'b0, 32'h104, 32'h0,         32'h0044_A5A5, 32'h0104_A5A5, k + 7);
        push(1'b0, 1'b1, 32'h48,  32'hCAFE_0001, 32'h0044_A5A5, 32'h0104_A5A5, k + 11);
        push(1'b1, 1'b0, 32'h108, 32'h0,         32'h0044_A5A5, 32'h0108_A5A5, k + 15);
        fork
            begin cpu_access(1'b0, 32'h44, 32'h0); @(negedge CLK); cpu_access(1'b1, 32'h48, 32'hCAFE_0001); end
            begin @(negedge CLK); dma_access(1'b0, 32'h104, 32'h0); @(negedge CLK); dma_access(1'b0, 32'h108, 32'h0); end
        join
        @(negedge CLK);

        // Reset in the second access cycle aborts the transfer without a done pulse.
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h40; b2.cpu_req = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b1; b2.cpu_req = 1'b0;
        @(negedge CLK);
        check("abort_ctrl", {28'd0, b2.busy, b2.mem_en, b2.mem_we, b2.cpu_done}, 32'd0);
        check("abort_rdata", b2.cpu_rdata, 32'h0);
        rst = 1'b0;
        @(negedge CLK);
        check("abort_no_done", {30'd0, b2.cpu_done, b2.dma_done}, 32'd0);
        k = cyc;
        push(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C0A_0004, 32'h0, k + 3);
        cpu_access(1'b0, 32'h40, 32'h0);
        repeat (3) @(negedge CLK);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
